// File: rtl/rca_pipeline_arbiter.sv
// rca_pipeline_arbiter
//   Shares one pipelined ripple-carry adder among NREQ requesters. A
//   round-robin arbiter issues at most one add per cycle. A {valid, owner}
//   tag pipe runs alongside the adder so that each result is steered to its
//   owner's response FIFO. Each requester has a credit counter that covers
//   ops in flight plus FIFO occupancy. Issue to a requester stops when its
//   credit count reaches RSP_DEPTH, so a FIFO can never overflow.
//
//   Ports
//     clk_i, rst_ni          clock, synchronous active-low reset
//     req_valid_i/ready_o    per-requester op handshake (ready one-hot or 0)
//     req_a_i, req_b_i       operands, requester i at [i*NBITS +: NBITS]
//     req_cin_i              per-requester carry-in
//     rsp_valid_o/ready_i    per-requester result handshake
//     rsp_sum_o, rsp_cout_o  result, same packing as the operands
//     stat_issued_o          (RCA_ARB_STATS_EN) saturating count of ops issued
//     stat_blocked_o         (RCA_ARB_STATS_EN) saturating count of cycles with
//                            some request valid but no grant
//
//   Optional feature macro: RCA_ARB_STATS_EN

module rca_adder_pipe #(
  parameter int NBITS   = 8,
  parameter int NSTAGES = 2
) (
  input  logic             clk_i,
  input  logic [NBITS-1:0] a_i,
  input  logic [NBITS-1:0] b_i,
  input  logic             cin_i,
  output logic [NBITS-1:0] sum_o,
  output logic             cout_o
);
  localparam int W = NBITS / NSTAGES;

  // Latency is NSTAGES+1. One input register is followed by one register per
  // chunk. Chunk j adds its operand slice in stage j. Operand slices are delayed
  // j cycles to meet their carry. Finished sum slices are delayed so that all
  // slices leave together.
  logic [NSTAGES:0]   c_q;
  logic [NSTAGES-1:0] c_nx;

  function automatic logic [W:0] rca(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic c);
    logic [W-1:0] s;
    logic         cy;
    s  = '0;
    cy = c;
    for (int j = 0; j < W; j++) begin
      s[j] = a[j] ^ b[j] ^ cy;
      cy   = (a[j] & b[j]) | (cy & (a[j] ^ b[j]));
    end
    return {cy, s};
  endfunction

  always_ff @(posedge clk_i) begin
    c_q[0]         <= cin_i;
    c_q[NSTAGES:1] <= c_nx;
  end

  for (genvar j = 0; j < NSTAGES; j++) begin : g_chunk
    logic [W-1:0] a_q [j+1];
    logic [W-1:0] b_q [j+1];
    logic [W-1:0] s_q [NSTAGES-j];
    logic [W:0]   r;

    assign r       = rca(a_q[j], b_q[j], c_q[j]);
    assign c_nx[j] = r[W];

    always_ff @(posedge clk_i) begin
      a_q[0] <= a_i[j*W +: W];
      b_q[0] <= b_i[j*W +: W];
      for (int k = 1; k <= j; k++) begin
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
      end
      s_q[0] <= r[W-1:0];
      for (int k = 1; k < NSTAGES - j; k++) s_q[k] <= s_q[k-1];
    end

    assign sum_o[j*W +: W] = s_q[NSTAGES-1-j];
  end

  assign cout_o = c_q[NSTAGES];
endmodule

// Per-requester lane. It holds the credit counter and the response FIFO.
module rca_arb_lane #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       issue_i,
  input  logic       wr_i,
  input  logic [W:0] wdata_i,
  input  logic       rsp_ready_i,
  output logic       rsp_valid_o,
  output logic [W:0] rdata_o,
  output logic       room_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W:0]    mem_q [DEPTH];
  logic [PW:0]   wr_q, rd_q;
  logic [CW-1:0] credit_q;
  logic          pop;

  assign rsp_valid_o = rst_ni && (wr_q != rd_q);
  assign rdata_o     = mem_q[rd_q[PW-1:0]];
  assign pop         = rsp_valid_o && rsp_ready_i;
  assign room_o      = credit_q < CW'(DEPTH);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q     <= '0;
      rd_q     <= '0;
      credit_q <= '0;
    end else begin
      if (wr_i) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      case ({issue_i, pop})
        2'b10:   credit_q <= credit_q + 1'b1;
        2'b01:   credit_q <= credit_q - 1'b1;
        default: credit_q <= credit_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_i) mem_q[wr_q[PW-1:0]] <= wdata_i;
  end
endmodule

module rca_pipeline_arbiter #(
  parameter int NREQ      = 4,
  parameter int NBITS     = 8,
  parameter int NSTAGES   = 2,
  parameter int RSP_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NREQ-1:0]       req_valid_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic [NREQ*NBITS-1:0] req_a_i,
  input  logic [NREQ*NBITS-1:0] req_b_i,
  input  logic [NREQ-1:0]       req_cin_i,
  output logic [NREQ-1:0]       rsp_valid_o,
  input  logic [NREQ-1:0]       rsp_ready_i,
  output logic [NREQ*NBITS-1:0] rsp_sum_o,
  output logic [NREQ-1:0]       rsp_cout_o
`ifdef RCA_ARB_STATS_EN
  ,
  output logic [15:0]           stat_issued_o,
  output logic [15:0]           stat_blocked_o
`endif
);
  localparam int LAT = NSTAGES + 1;
  localparam int IW  = $clog2(NREQ);

  if ((NBITS % NSTAGES) != 0 || (RSP_DEPTH & (RSP_DEPTH - 1)) != 0 || RSP_DEPTH < 2 ||
      (NSTAGES & (NSTAGES - 1)) != 0 || NREQ < 2 || NREQ > 8) begin : g_bad_cfg
    $fatal(1, "rca_pipeline_arbiter: illegal parameter combination");
  end

  logic [IW-1:0]   rr_q;
  logic [NREQ-1:0] room;
  logic            issue;
  logic [IW-1:0]   gnt;

  // Scan from rr_q with wrap. Gating on rst_ni keeps ready low during reset.
  always_comb begin : p_arb
    int idx;
    idx   = 0;
    issue = 1'b0;
    gnt   = '0;
    for (int off = 0; off < NREQ; off++) begin
      idx = int'(rr_q) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!issue && rst_ni && req_valid_i[idx] && room[idx]) begin
        issue = 1'b1;
        gnt   = IW'(idx);
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (issue) req_ready_o[gnt] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni)    rr_q <= '0;
    else if (issue) rr_q <= (int'(gnt) == NREQ - 1) ? '0 : gnt + 1'b1;
  end

  // Shared adder. It has no valid or stall, so only the tag pipe says whether
  // its output means anything.
  logic [NBITS-1:0] add_sum;
  logic             add_cout;

  rca_adder_pipe #(.NBITS(NBITS), .NSTAGES(NSTAGES)) u_add (
    .clk_i  (clk_i),
    .a_i    (req_a_i[gnt*NBITS +: NBITS]),
    .b_i    (req_b_i[gnt*NBITS +: NBITS]),
    .cin_i  (req_cin_i[gnt]),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  logic [LAT-1:0] vld_pipe_q;
  logic [IW-1:0]  own_pipe_q [LAT];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) vld_pipe_q <= '0;
    else         vld_pipe_q <= {vld_pipe_q[LAT-2:0], issue};
  end

  always_ff @(posedge clk_i) begin
    own_pipe_q[0] <= gnt;
    for (int k = 1; k < LAT; k++) own_pipe_q[k] <= own_pipe_q[k-1];
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    logic [NBITS:0] rdata;

    rca_arb_lane #(.W(NBITS), .DEPTH(RSP_DEPTH)) u_lane (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .issue_i     (req_ready_o[i]),
      .wr_i        (vld_pipe_q[LAT-1] && (int'(own_pipe_q[LAT-1]) == i)),
      .wdata_i     ({add_cout, add_sum}),
      .rsp_ready_i (rsp_ready_i[i]),
      .rsp_valid_o (rsp_valid_o[i]),
      .rdata_o     (rdata),
      .room_o      (room[i])
    );

    assign rsp_sum_o[i*NBITS +: NBITS] = rdata[NBITS-1:0];
    assign rsp_cout_o[i]               = rdata[NBITS];
  end

`ifdef RCA_ARB_STATS_EN
  logic [15:0] issued_q, blocked_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      issued_q  <= '0;
      blocked_q <= '0;
    end else begin
      if (issue && issued_q != 16'hFFFF) issued_q <= issued_q + 1'b1;
      if (|req_valid_i && !issue && blocked_q != 16'hFFFF) blocked_q <= blocked_q + 1'b1;
    end
  end

  assign stat_issued_o  = issued_q;
  assign stat_blocked_o = blocked_q;
`endif
endmodule

// File: tb/tb_rca_pipeline_arbiter.sv
module tb_rca_pipeline_arbiter;
  localparam int NREQ = 4, NBITS = 8, NSTAGES = 2, RSP_DEPTH = 4;
  localparam int LAT = NSTAGES + 1;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req_valid = '0, req_ready, req_cin = '0;
  logic [NREQ*NBITS-1:0] req_a = '0, req_b = '0, rsp_sum;
  logic [NREQ-1:0]       rsp_valid, rsp_ready = '0, rsp_cout;

  always #5 clk = ~clk;

  rca_pipeline_arbiter #(.NREQ(NREQ), .NBITS(NBITS), .NSTAGES(NSTAGES), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b), .req_cin_i(req_cin),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_sum_o(rsp_sum), .rsp_cout_o(rsp_cout)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic mid();  @(negedge clk);     endtask

  function automatic logic [8:0] ref_add(input logic [7:0] a, input logic [7:0] b, input logic c);
    return 9'(a) + 9'(b) + 9'(c);
  endfunction

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic c);
    req_a[i*NBITS +: NBITS] = a;
    req_b[i*NBITS +: NBITS] = b;
    req_cin[i]              = c;
  endtask

  function automatic logic [8:0] rsp_of(input int i);
    return {rsp_cout[i], rsp_sum[i*NBITS +: NBITS]};
  endfunction

  task automatic do_reset(input int n);
    req_valid = '0;
    rst_n     = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    int         idx;
    logic [7:0] a, b;
    logic       cin;
    logic [7:0] s;
    logic       co;
  } vec_t;

  typedef struct {
    int         t;
    logic [8:0] v;
  } ent_t;

  // Abstract reference model: per-requester outstanding count, rr pointer,
  // and queues of expected results stamped with the cycle they become visible.
  int   m_rr, m_cyc, m_issued;
  int   m_cred [NREQ];
  ent_t m_q [NREQ][$];

  task automatic model_cycle();
    int g, i;
    logic [NREQ-1:0] exp_rdy, exp_rv;
    ent_t e;
    g = -1;
    for (int off = 0; off < NREQ; off++) begin
      i = (m_rr + off) % NREQ;
      if (g < 0 && req_valid[i] && m_cred[i] < RSP_DEPTH) g = i;
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    exp_rv = '0;
    for (int k = 0; k < NREQ; k++)
      exp_rv[k] = (m_q[k].size() > 0) && (m_q[k][0].t <= m_cyc);
    chk("rnd_ready", 32'(req_ready), 32'(exp_rdy));
    chk("rnd_valid", 32'(rsp_valid), 32'(exp_rv));
    for (int k = 0; k < NREQ; k++) begin
      if (exp_rv[k] && rsp_ready[k]) begin
        e = m_q[k].pop_front();
        chk("rnd_data", 32'(rsp_of(k)), 32'(e.v));
        m_cred[k]--;
      end
    end
    if (g >= 0) begin
      e.t = m_cyc + LAT + 1;
      e.v = ref_add(req_a[g*NBITS +: NBITS], req_b[g*NBITS +: NBITS], req_cin[g]);
      m_q[g].push_back(e);
      m_cred[g]++;
      m_rr = (g + 1) % NREQ;
      m_issued++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [6];
    int   lat, acc, k;
    int   got [NREQ];
    logic seen;
    logic [7:0] ra, rb;
    logic [8:0] ev;

    tbl[0] = '{0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    tbl[1] = '{0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
    tbl[2] = '{0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tbl[3] = '{2, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    tbl[4] = '{3, 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    tbl[5] = '{1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};

    // Reset state: all requesting, nothing may be accepted or returned.
    req_valid = '1;
    repeat (2) tick();
    mid();
    chk("reset_ready", 32'(req_ready), 0);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    tick();
    req_valid = '0;
    rst_n     = 1'b1;

    // Table-driven single ops: latency, sum and carry.
    foreach (tbl[n]) begin
      set_op(tbl[n].idx, tbl[n].a, tbl[n].b, tbl[n].cin);
      req_valid = '0;
      req_valid[tbl[n].idx] = 1'b1;
      rsp_ready = '0;
      mid();
      chk("tbl_ready", 32'(req_ready), 32'(1 << tbl[n].idx));
      tick();
      req_valid = '0;
      lat = 1;
      mid();
      while (!rsp_valid[tbl[n].idx] && lat < 12) begin
        tick(); lat++; mid();
      end
      chk("tbl_latency", lat, LAT + 1);
      chk("tbl_sum", 32'(rsp_sum[tbl[n].idx*NBITS +: NBITS]), 32'(tbl[n].s));
      chk("tbl_cout", 32'(rsp_cout[tbl[n].idx]), 32'(tbl[n].co));
      rsp_ready[tbl[n].idx] = 1'b1;
      tick();
      rsp_ready = '0;
      mid();
      chk("tbl_popped", 32'(rsp_valid), 0);
      tick();
    end

    // Round robin with all requesters valid.
    do_reset(2);
    rsp_ready = '1;
    for (int i = 0; i < NREQ; i++) begin
      set_op(i, 8'h3C + 8'(8'h45 * i), 8'hC7 - 8'(i), 1'(i));
      got[i] = 0;
    end
    req_valid = '1;
    for (int c = 0; c < 16; c++) begin
      if (c == 8) req_valid = '0;
      mid();
      if (c < 8) chk("rr_grant", 32'(req_ready), 32'(1 << (c % NREQ)));
      for (int i = 0; i < NREQ; i++) begin
        if (rsp_valid[i]) begin
          chk("rr_data", 32'(rsp_of(i)),
              32'(ref_add(8'h3C + 8'(8'h45 * i), 8'hC7 - 8'(i), 1'(i))));
          got[i]++;
        end
      end
      tick();
    end
    for (int i = 0; i < NREQ; i++) chk("rr_count", got[i], 2);

    // Backpressure on requester 1: credits cap it at RSP_DEPTH accepts.
    do_reset(2);
    rsp_ready = 4'b1101;
    acc = 0;
    set_op(0, 8'h01, 8'h02, 1'b0);
    set_op(1, 8'h00, 8'h01, 1'b0);
    req_valid = 4'b0011;
    for (int c = 0; c < 20; c++) begin
      mid();
      if (c == 19) chk("bp_others_granted", 32'(req_ready), 32'h1);
      if (req_ready[1]) acc++;
      tick();
      set_op(1, 8'(acc), 8'h01, 1'b0);
    end
    chk("bp_accepts", acc, RSP_DEPTH);
    req_valid = '0;
    rsp_ready = '1;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      mid();
      if (rsp_valid[1]) begin
        chk("bp_order", 32'(rsp_of(1)), 32'(k + 1));
        k++;
      end
      tick();
    end
    chk("bp_drained", k, RSP_DEPTH);
    set_op(1, 8'h20, 8'h22, 1'b0);
    req_valid = 4'b0010;
    mid();
    chk("bp_resume", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;

    // Reset with two ops in flight.
    do_reset(2);
    rsp_ready = '0;
    set_op(0, 8'h11, 8'h22, 1'b0);
    set_op(1, 8'h33, 8'h44, 1'b1);
    req_valid = 4'b0011;
    mid(); chk("rst_issue0", 32'(req_ready), 32'h1); tick();
    mid(); chk("rst_issue1", 32'(req_ready), 32'h2); tick();
    set_op(2, 8'h33, 8'h44, 1'b1);
    req_valid = 4'b0100;
    rst_n = 1'b0;
    tick();
    mid();
    chk("rst_ready_low", 32'(req_ready), 0);
    chk("rst_rsp_low", 32'(rsp_valid), 0);
    tick();
    rst_n = 1'b1;
    rsp_ready = 4'b0100;
    mid();
    chk("rst_first_grant", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    seen = 1'b0;
    for (int c = 0; c < LAT + 4; c++) begin
      mid();
      chk("rst_no_stale", 32'(rsp_valid & 4'b1011), 0);
      if (rsp_valid[2]) begin
        chk("rst_new_data", 32'(rsp_of(2)), 32'h078);
        seen = 1'b1;
      end
      tick();
    end
    chk("rst_new_seen", 32'(seen), 1);

    // Randomized traffic against the reference model.
    do_reset(2);
    m_rr = 0; m_cyc = 0; m_issued = 0;
    for (int i = 0; i < NREQ; i++) begin
      m_cred[i] = 0;
      m_q[i].delete();
    end
    while (m_issued < 10000 && m_cyc < 50000) begin
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i] = ($urandom_range(3) != 0);
        rsp_ready[i] = ($urandom_range(9) < 7);
        ra = 8'($urandom());
        rb = 8'($urandom());
        set_op(i, ra, rb, 1'($urandom()));
      end
      mid();
      model_cycle();
      tick();
      m_cyc++;
    end
    req_valid = '0;
    rsp_ready = '1;
    for (int c = 0; c < 3 * RSP_DEPTH + LAT + 4; c++) begin
      mid();
      model_cycle();
      tick();
      m_cyc++;
    end
    chk("rnd_issued", 32'(m_issued >= 10000), 1);
    for (int i = 0; i < NREQ; i++) chk("rnd_all_returned", m_q[i].size(), 0);
    ev = 9'h0;
    chk("rnd_idle_valid", 32'(rsp_valid), 32'(ev));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
